// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: gated edge-count frequency meter controller with window averaging
module freq_meas_ctrl #(
  parameter int GATE_BASE = 3125000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        cont,
  input  logic [1:0]  gate_sel,
  input  logic [1:0]  avg_sel,
  input  logic [15:0] cnt_in,
  output logic        cnt_clr,
  output logic        gate_en,
  output logic [15:0] freq,
  output logic        freq_valid,
  input  logic        freq_ack,
  output logic        ovf,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SAMPLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [1:0] cfg_gate, cfg_avg;
  logic [18:0] acc;
  logic [2:0] idx, n_last;
  logic [27:0] gcnt, g_len;
  logic [22:0] r;
  logic rearm, cnt_clr_d, gate_en_d, valid_d, busy_d;
  assign g_len = 28'(GATE_BASE) << cfg_gate;
  assign n_last = 3'((4'd1 << cfg_avg) - 4'd1);
  assign r = 23'(acc >> cfg_avg) << (3'd4 - {1'b0, cfg_gate});
  assign rearm = !abort && ((state == IDLE && start) || (state == DONE && cont));
  // State and registered outputs; outputs are decoded from the next state so they align with it
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt_clr <= 1'b0;
      gate_en <= 1'b0;
      freq_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt_clr <= cnt_clr_d;
      gate_en <= gate_en_d;
      freq_valid <= valid_d;
      busy <= busy_d;
    end
  end
  // Next state; abort overrides everything, including start sampled in IDLE
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = start ? CLEAR : IDLE;
        CLEAR:   nxt = GATE;
        GATE:    nxt = (gcnt == g_len - 28'd1) ? SAMPLE : GATE;
        SAMPLE:  nxt = (idx == n_last) ? CALC : CLEAR;
        CALC:    nxt = DONE;
        DONE:    nxt = cont ? CLEAR : (freq_ack ? IDLE : DONE);
        default: nxt = IDLE;
      endcase
  end
  // Output decode of the upcoming state
  always_comb begin
    cnt_clr_d = nxt == CLEAR;
    gate_en_d = nxt == GATE;
    valid_d = nxt == DONE;
    busy_d = nxt != IDLE;
  end
  // Datapath: config latch, accumulation, gate timing and saturated result
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cfg_gate <= '0;
      cfg_avg <= '0;
      acc <= '0;
      idx <= '0;
      gcnt <= '0;
      freq <= '0;
      ovf <= 1'b0;
    end else begin
      if (rearm) begin
        cfg_gate <= gate_sel;
        cfg_avg <= avg_sel;
        acc <= '0;
        idx <= '0;
      end else if (state == SAMPLE && !abort) begin
        acc <= acc + 19'(cnt_in);
        idx <= idx + 3'd1;
      end
      gcnt <= (state == GATE) ? gcnt + 28'd1 : '0;
      if (state == CALC && !abort) begin
        freq <= (r > 23'hFFFF) ? 16'hFFFF : r[15:0];
        ovf <= r > 23'hFFFF;
      end
    end
  end
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: table, random and corner-sequence checks of freq_meas_ctrl with GATE_BASE=8
module tb_freq_meas_ctrl;
  logic mclk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, cont = 1'b0, freq_ack = 1'b0;
  logic [1:0] gate_sel = '0, avg_sel = '0;
  logic [15:0] cnt_in = '0;
  logic cnt_clr, gate_en, freq_valid, ovf, busy;
  logic [15:0] freq;
  int vectors = 0, miscompares = 0;
  logic [15:0] exp_f = '0;
  logic exp_o = 1'b0;

  typedef struct packed {
    logic [1:0] g;
    logic [1:0] a;
    logic [7:0][15:0] v;
    logic [15:0] f;
    logic o;
  } vec_t;

  freq_meas_ctrl #(.GATE_BASE(8)) dut (
    .mclk(mclk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .gate_sel(gate_sel), .avg_sel(avg_sel), .cnt_in(cnt_in), .cnt_clr(cnt_clr),
    .gate_en(gate_en), .freq(freq), .freq_valid(freq_valid), .freq_ack(freq_ack),
    .ovf(ovf), .busy(busy)
  );

  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference: average of N windows, scaled to Hz by 16/2^g, saturated at 16 bits
  function automatic void model(input logic [1:0] g, input logic [1:0] a,
                                input logic [7:0][15:0] v, output logic [15:0] f, output logic o);
    longint sum = 0, rr;
    for (int j = 0; j < (1 << a); j++) sum += longint'(v[j]);
    rr = (sum / (1 << a)) * (16 >> g);
    o = rr > 65535;
    f = o ? 16'hFFFF : 16'(rr);
  endfunction

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!freq_valid && n < budget) begin
      @(negedge mclk);
      n++;
    end
  endtask

  task automatic measure(input vec_t t, input string tag);
    int n = 1 << t.a, gl = 8 << t.g, k = 0, w = 0, clr = 0, gat = 0;
    @(negedge mclk);
    gate_sel = t.g; avg_sel = t.a; cont = 1'b0; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    gate_sel = 2'($urandom); avg_sel = 2'($urandom);
    while (!freq_valid && k < 2000) begin
      if (cnt_clr) begin
        clr++;
        if (w < 8) cnt_in = t.v[w];
        w++;
      end
      if (gate_en) gat++;
      @(negedge mclk);
      k++;
    end
    check({tag, " latency"}, k, n * (gl + 2) + 1);
    check({tag, " freq"}, freq, t.f);
    check({tag, " ovf"}, ovf, t.o);
    check({tag, " clr count"}, clr, n);
    check({tag, " gate cycles"}, gat, n * gl);
    exp_f = t.f; exp_o = t.o;
    repeat (2) @(negedge mclk);
    check({tag, " valid hold"}, freq_valid, 1);
    freq_ack = 1'b1;
    @(negedge mclk);
    freq_ack = 1'b0;
    check({tag, " ack release"}, {freq_valid, busy}, 0);
  endtask

  initial begin
    vec_t tbl [9];
    vec_t t;
    int n;
    logic seen;
    tbl[0] = '{2'd0, 2'd0, {8{16'd5}}, 16'd80, 1'b0};
    tbl[1] = '{2'd1, 2'd2, {64'd0, 16'd16, 16'd14, 16'd12, 16'd10}, 16'd104, 1'b0};
    tbl[2] = '{2'd0, 2'd0, {8{16'd5000}}, 16'hFFFF, 1'b1};
    tbl[3] = '{2'd3, 2'd3, {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 16'd8, 1'b0};
    tbl[4] = '{2'd2, 2'd1, {96'd0, 16'd4097, 16'd4095}, 16'd16384, 1'b0};
    tbl[5] = '{2'd0, 2'd0, {8{16'd4095}}, 16'd65520, 1'b0};
    tbl[6] = '{2'd0, 2'd0, {8{16'd4096}}, 16'hFFFF, 1'b1};
    tbl[7] = '{2'd3, 2'd0, {8{16'd65535}}, 16'hFFFF, 1'b1};
    tbl[8] = '{2'd3, 2'd3, {8{16'd65535}}, 16'hFFFF, 1'b1};
    #1;
    check("reset outputs", {cnt_clr, gate_en, freq_valid, ovf, busy, freq}, 0);
    #20 rst = 1'b0;
    for (int i = 0; i < 9; i++) measure(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 24; i++) begin
      int lim = (i % 3 == 0) ? 65535 : (i % 3 == 1) ? 4000 : 600;
      t.g = 2'($urandom_range(0, 3));
      t.a = 2'($urandom_range(0, 3));
      for (int j = 0; j < 8; j++) t.v[j] = 16'($urandom_range(0, lim));
      model(t.g, t.a, t.v, t.f, t.o);
      measure(t, $sformatf("rnd%0d", i));
    end
    // continuous mode: 1-cycle pulses, config change applies from the next measurement
    @(negedge mclk);
    cnt_in = 16'd5; gate_sel = 2'd0; avg_sel = 2'd0; cont = 1'b1; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    wait_valid(100, n);
    check("cont first latency", n, 11);
    check("cont first freq", freq, 80);
    @(negedge mclk);
    check("cont pulse width", freq_valid, 0);
    gate_sel = 2'd1;
    wait_valid(100, n);
    check("cont period g0", n, 11);
    check("cont freq still g0", freq, 80);
    @(negedge mclk);
    check("cont pulse width 2", freq_valid, 0);
    wait_valid(100, n);
    check("cont period g1", n, 19);
    check("cont freq g1", freq, 40);
    exp_f = 16'd40; exp_o = 1'b0;
    @(negedge mclk);
    cont = 1'b0; abort = 1'b1;
    @(negedge mclk);
    abort = 1'b0;
    check("cont abort busy", busy, 0);
    // abort during GATE
    @(negedge mclk);
    gate_sel = 2'd0; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (2) @(negedge mclk);
    check("abort pre gate_en", gate_en, 1);
    abort = 1'b1;
    @(negedge mclk);
    abort = 1'b0;
    check("abort gate_en/busy", {gate_en, busy}, 0);
    check("abort keeps result", {ovf, freq}, {exp_o, exp_f});
    seen = 1'b0;
    repeat (30) begin
      @(negedge mclk);
      seen |= freq_valid | busy;
    end
    check("abort no result", seen, 0);
    // start while busy is ignored; start+ack in DONE only returns to IDLE
    gate_sel = 2'd0; avg_sel = 2'd0; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (3) @(negedge mclk);
    gate_sel = 2'd3; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    wait_valid(100, n);
    check("busy start latency", n, 7);
    check("busy start freq", freq, 80);
    start = 1'b1; freq_ack = 1'b1;
    @(negedge mclk);
    start = 1'b0; freq_ack = 1'b0;
    check("start+ack idle", {freq_valid, busy}, 0);
    repeat (3) @(negedge mclk);
    check("start+ack no restart", busy, 0);
    // asynchronous reset mid-GATE
    gate_sel = 2'd0; start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    repeat (4) @(negedge mclk);
    #2 rst = 1'b1;
    #1;
    check("async reset outputs", {cnt_clr, gate_en, freq_valid, ovf, busy, freq}, 0);
    #4 rst = 1'b0;
    measure(tbl[0], "post reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
